crc_frame_serializer: RTL and testbench

Parametrised successor to the domain-2 CRC/serializer. It accepts payload words with a per-word CRC mode into a DEPTH-entry FIFO. It then transmits each entry as a framed, MSB-first serial packet with a bit-serially computed CRC-8 or CRC-16 trailer. The block sits in the sys_clk domain and is fed by the synchronised SPI register file (write strobe, data, mode). It reports completion per frame with a one-cycle done tick.

---
 rtl/crc_frame_serializer_pkg.sv | 18 +
 rtl/crc_frame_serializer_lfsr.sv | 45 ++++
 rtl/crc_frame_serializer.sv | 172 +++++++++++++++++
 tb/tb_crc_frame_serializer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_frame_serializer_pkg.sv
// Shared constants and FSM encoding for the CRC frame serializer.
// Polynomials are stored without their implicit top term.
package crc_frame_serializer_pkg;

    localparam logic [7:0]  CRC8_POLY  = 8'h07;
    localparam logic [7:0]  CRC8_INIT  = 8'h00;
    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_CRC   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

endpackage

// File: rtl/crc_frame_serializer_lfsr.sv
// Bit-serial CRC-8 / CRC-16 register, MSB-first, no reflection, no final XOR.
// In CRC-8 mode only the low byte is active and the high byte stays zero.
module crc_serial_lfsr
    import crc_frame_serializer_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        init,
    input  logic        shift_en,
    input  logic        data_bit,
    input  logic        mode,
    output logic [15:0] crc
);

    logic [15:0] crc_reg;
    logic [15:0] crc_next;
    logic        fb;

    always_comb begin
        crc_next = crc_reg;
        fb       = 1'b0;
        if (init) begin
            crc_next = mode ? CRC16_INIT : {8'h00, CRC8_INIT};
        end else if (shift_en) begin
            if (mode) begin
                fb       = data_bit ^ crc_reg[15];
                crc_next = {crc_reg[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
            end else begin
                fb       = data_bit ^ crc_reg[7];
                crc_next = {8'h00, crc_reg[6:0], 1'b0} ^ {8'h00, (fb ? CRC8_POLY : 8'h00)};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            crc_reg <= 16'h0000;
        end else begin
            crc_reg <= crc_next;
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/crc_frame_serializer.sv
// FIFO-fed serializer: each entry becomes START, payload MSB-first, CRC trailer, STOP.
// The CRC register is frozen while its bits are shifted out.
module crc_frame_serializer
    import crc_frame_serializer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         payload,
    input  logic                     mode,
    output logic                     packet,
    output logic                     busy,
    output logic                     serial_done_tick,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH + 16);
    localparam logic [AW-1:0] PTR_ONE   = 1;
    localparam logic [AW:0]   LVL_ONE   = 1;
    localparam logic [AW:0]   LVL_FULL  = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = 1;
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);

    // Each entry carries its own mode in the top bit.
    logic [WIDTH:0]  mem [DEPTH];
    logic [WIDTH:0]  head;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW:0]     level_reg;
    logic [AW:0]     level_next;
    logic            full_reg;
    logic            empty_reg;
    logic            overflow_reg;
    logic            push;
    logic            pop;

    state_t          state_reg;
    state_t          state_next;
    logic [WIDTH-1:0] shift_reg;
    logic            mode_reg;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   crc_last;
    logic [3:0]      crc_idx;
    logic [15:0]     crc;

    assign head     = mem[rd_ptr_reg];
    assign push     = wr_en && !full_reg;
    assign crc_last = mode_reg ? CW'(15) : CW'(7);
    assign crc_idx  = (mode_reg ? 4'd15 : 4'd7) - cnt_reg[3:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {mode, payload};
        end
    end

    always_comb begin
        level_next = level_reg;
        if (push && !pop) begin
            level_next = level_reg + LVL_ONE;
        end else if (!push && pop) begin
            level_next = level_reg - LVL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            level_reg <= level_next;
            full_reg  <= (level_next == LVL_FULL);
            empty_reg <= (level_next == '0);
            if (wr_en && full_reg) overflow_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pop              = 1'b0;
        packet           = 1'b1;
        busy             = 1'b0;
        serial_done_tick = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!empty_reg) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                packet     = 1'b0;
                busy       = 1'b1;
                state_next = ST_DATA;
            end
            ST_DATA: begin
                packet = shift_reg[WIDTH-1];
                busy   = 1'b1;
                if (cnt_reg == DATA_LAST) state_next = ST_CRC;
            end
            ST_CRC: begin
                packet = crc[crc_idx];
                busy   = 1'b1;
                if (cnt_reg == crc_last) state_next = ST_STOP;
            end
            ST_STOP: begin
                busy             = 1'b1;
                serial_done_tick = 1'b1;
                state_next       = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The pop itself is the registered read of the FIFO head.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            shift_reg <= '0;
            mode_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            if (pop) begin
                shift_reg <= head[WIDTH-1:0];
                mode_reg  <= head[WIDTH];
            end else if (state_reg == ST_DATA) begin
                shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            end
            if (state_next != state_reg) begin
                cnt_reg <= '0;
            end else if (state_reg == ST_DATA || state_reg == ST_CRC) begin
                cnt_reg <= cnt_reg + CNT_ONE;
            end
        end
    end

    crc_serial_lfsr u_lfsr (
        .clk      (clk),
        .resetn   (resetn),
        .init     (pop),
        .shift_en (state_reg == ST_DATA),
        .data_bit (shift_reg[WIDTH-1]),
        .mode     (pop ? head[WIDTH] : mode_reg),
        .crc      (crc)
    );

    assign full     = full_reg;
    assign empty    = empty_reg;
    assign level    = level_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Scoreboard bench: a cycle-level FIFO/occupancy model queues expected frames,
// and a negedge monitor captures the serial line and checks status every cycle.
module tb_crc_frame_serializer;

    localparam int W  = 72;
    localparam int D  = 4;
    localparam int LW = $clog2(D) + 1;
    localparam int FW = W + 18;

    typedef struct {
        logic [FW-1:0] frame;
        int            len;
        int            start;
    } exp_t;

    typedef struct {
        logic [W-1:0] d;
        bit           m;
    } ent_t;

    logic          clk;
    logic          resetn;
    logic          wr_en;
    logic [W-1:0]  payload;
    logic          mode;
    logic          packet;
    logic          busy;
    logic          serial_done_tick;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          overflow;

    crc_frame_serializer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .wr_en            (wr_en),
        .payload          (payload),
        .mode             (mode),
        .packet           (packet),
        .busy             (busy),
        .serial_done_tick (serial_done_tick),
        .full             (full),
        .empty            (empty),
        .level            (level),
        .overflow         (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    n_cmp = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    cd = 0;
    bit    m_ovf = 0;
    bit    abort = 0;
    ent_t  fq[$];
    exp_t  sb[$];

    bit            capturing = 0;
    exp_t          cur;
    logic [FW-1:0] cap;
    int            cap_n;
    int            frames_done = 0;
    int            last_len = 0;
    logic [15:0]   last_crc = 0;
    int            last_start = 0;
    int            prev_start = 0;

    // CRC as the remainder of (M*x^C xor init*x^W) mod P, by long division.
    function automatic logic [15:0] ref_crc(logic [W-1:0] d, bit m);
        int            c = m ? 16 : 8;
        logic [16:0]   p = m ? 17'h11021 : 17'h00107;
        logic [15:0]   init = m ? 16'hFFFF : 16'h0000;
        logic [W+15:0] v = '0;
        logic [15:0]   r = '0;
        for (int i = 0; i < W; i++) v[i + c] = d[i];
        for (int i = 0; i < c; i++) v[W + i] = v[W + i] ^ init[i];
        for (int i = W + c - 1; i >= c; i--) begin
            if (v[i]) begin
                for (int j = 0; j <= c; j++) v[i - c + j] = v[i - c + j] ^ p[j];
            end
        end
        for (int i = 0; i < c; i++) r[i] = v[i];
        return r;
    endfunction

    function automatic exp_t make_exp(logic [W-1:0] d, bit m, int start);
        exp_t        e;
        int          c = m ? 16 : 8;
        logic [15:0] crc = ref_crc(d, m);
        e.frame = '0;
        for (int i = W - 1; i >= 0; i--) e.frame = (e.frame << 1) | FW'(d[i]);
        for (int i = c - 1; i >= 0; i--) e.frame = (e.frame << 1) | FW'(crc[i]);
        e.frame = (e.frame << 1) | FW'(1);
        e.len   = W + c + 2;
        e.start = start;
        return e;
    endfunction

    // Reference model: occupancy queue plus a countdown for the frame in flight.
    always @(posedge clk) begin
        int   sz;
        bit   do_pop;
        bit   do_push;
        ent_t e;
        cyc++;
        if (!resetn) begin
            fq.delete();
            sb.delete();
            cd    = 0;
            m_ovf = 0;
            abort = 1;
        end else begin
            sz      = fq.size();
            do_pop  = (cd == 0) && (sz > 0);
            do_push = wr_en && (sz < D);
            if (wr_en && sz == D) m_ovf = 1;
            if (cd > 0) cd--;
            if (do_pop) begin
                e = fq.pop_front();
                sb.push_back(make_exp(e.d, e.m, cyc));
                cd = W + (e.m ? 16 : 8) + 2;
            end
            if (do_push) begin
                e.d = payload;
                e.m = mode;
                fq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        int   exp_lvl;
        bit   exp_busy;
        bit   exp_done;
        bit   exp_pkt_chk;
        bit   exp_pkt;
        if (abort) begin
            capturing = 0;
            abort     = 0;
        end
        exp_lvl     = fq.size();
        exp_busy    = (cd > 0);
        exp_done    = (cd == 1);
        exp_pkt_chk = (cd == 0) || (sb.size() == 0 && !capturing && cd > 0);
        exp_pkt     = 1'b1;
        n_cmp++;
        if (busy !== exp_busy || serial_done_tick !== exp_done || level !== LW'(exp_lvl) ||
            full !== (exp_lvl == D) || empty !== (exp_lvl == 0) || overflow !== m_ovf ||
            (exp_pkt_chk && packet !== exp_pkt)) begin
            n_fail++;
            $display("FAIL status cyc=%0d got busy=%b done=%b level=%0d full=%b empty=%b ovf=%b pkt=%b exp busy=%b done=%b level=%0d ovf=%b",
                     cyc, busy, serial_done_tick, level, full, empty, overflow, packet,
                     exp_busy, exp_done, exp_lvl, m_ovf);
        end
        if (capturing) begin
            cap = (cap << 1) | FW'(packet);
            cap_n++;
            if (cap_n == cur.len) begin
                n_cmp++;
                if (cap !== cur.frame) begin
                    n_fail++;
                    $display("FAIL frame start=%0d got %h exp %h", cur.start, cap, cur.frame);
                end
                last_len = cap_n;
                last_crc = cap[16:1];
                if (cur.len != W + 18) last_crc = last_crc & 16'h00FF;
                frames_done++;
                capturing = 0;
            end
        end else if (packet === 1'b0) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_start cyc=%0d got packet=0 exp idle 1", cyc);
            end else begin
                cur = sb.pop_front();
                if (cyc != cur.start) begin
                    n_fail++;
                    $display("FAIL start_cycle got %0d exp %0d", cyc, cur.start);
                end
                capturing  = 1;
                cap        = '0;
                cap_n      = 1;
                prev_start = last_start;
                last_start = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h exp %0h", name, act, exp);
        end
    endtask

    task automatic push(logic [W-1:0] d, bit m);
        wr_en   = 1'b1;
        payload = d;
        mode    = m;
        tick();
        wr_en   = 1'b0;
        $display("push payload=%h mode=%0d cyc=%0d", d, m, cyc);
    endtask

    task automatic drain(int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0 && fq.size() == 0 && cd == 0 && !capturing) return;
            tick();
        end
        n_cmp++;
        n_fail++;
        $display("FAIL drain_timeout got pending=%0d exp 0", fq.size() + sb.size());
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    logic [W-1:0] check_str;
    logic [W-1:0] rnd;
    int           f0;

    initial begin
        resetn  = 1'b0;
        wr_en   = 1'b0;
        payload = '0;
        mode    = 1'b0;
        repeat (3) tick();
        chk("reset_packet", 64'(packet), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(serial_done_tick), 64'd0);
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_full", 64'(full), 64'd0);
        chk("reset_level", 64'(level), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        resetn = 1'b1;
        tick();

        // "123456789" check values for both CRC widths.
        check_str = 72'h313233343536373839;
        push(check_str, 1'b1);
        drain(300);
        chk("crc16_field", 64'(last_crc), 64'h29B1);
        chk("crc16_len", 64'(last_len), 64'd90);
        push(check_str, 1'b0);
        drain(300);
        chk("crc8_field", 64'(last_crc), 64'hF4);
        chk("crc8_len", 64'(last_len), 64'd82);

        // Back-to-back: START-to-START is W + 8 + 3 for a CRC-8 first frame.
        push('0, 1'b0);
        push('1, 1'b1);
        drain(400);
        chk("b2b_period", 64'(last_start - prev_start), 64'(W + 11));

        // Six consecutive pushes: one entry drains during the burst, so five frames.
        f0 = frames_done;
        for (int i = 0; i < 6; i++) push(W'({$urandom(), $urandom(), $urandom()}), 1'($urandom_range(0, 1)));
        chk("overflow_set", 64'(overflow), 64'd1);
        drain(1000);
        chk("overflow_frames", 64'(frames_done - f0), 64'd5);
        chk("overflow_sticky", 64'(overflow), 64'd1);
        do_reset();
        chk("overflow_cleared", 64'(overflow), 64'd0);

        // Reset during DATA bit 10: start at +2 after the push edge, DATA bit 10 eleven later.
        push(W'({$urandom(), $urandom(), $urandom()}), 1'b1);
        repeat (12) tick();
        chk("midframe_busy", 64'(busy), 64'd1);
        do_reset();
        chk("midreset_packet", 64'(packet), 64'd1);
        chk("midreset_empty", 64'(empty), 64'd1);
        chk("midreset_level", 64'(level), 64'd0);
        push(W'({$urandom(), $urandom(), $urandom()}), 1'b0);
        drain(300);

        // Push on the IDLE pop cycle: level holds at 1.
        push(W'({$urandom(), $urandom(), $urandom()}), 1'b0);
        push(W'({$urandom(), $urandom(), $urandom()}), 1'b1);
        for (int i = 0; i < 200 && serial_done_tick !== 1'b1; i++) tick();
        chk("pushpop_stop_seen", 64'(serial_done_tick), 64'd1);
        tick();
        push(W'({$urandom(), $urandom(), $urandom()}), 1'b0);
        chk("pushpop_level", 64'(level), 64'd1);
        drain(600);

        // Randomized traffic, including overflow bursts.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 6) begin
                rnd = W'({$urandom(), $urandom(), $urandom()});
                push(rnd, 1'($urandom_range(0, 1)));
            end else begin
                tick();
            end
        end
        drain(1200);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
